// File: rtl/stream_width_packer.sv
// Packs PACK_RATIO narrow input words into one wide output word, little-endian by lane.
// Define STREAM_WIDTH_PACKER_FLUSH_EN to add the flush port for emitting partial words.

module stream_width_packer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module stream_width_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PACK_RATIO-1:0]            out_keep,
  input  logic                             clear,
`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
  input  logic                             flush,
`endif
  output logic [$clog2(PACK_RATIO):0]      count
);
  localparam int IW = $clog2(PACK_RATIO);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic                                 vld;
    logic [PACK_RATIO-1:0]                keep;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] data;
  } obuf_t;

  obuf_t                                 obuf_q, obuf_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc_q, acc_nxt;
  logic [PACK_RATIO-1:0]                 lane_we, keep_nxt;
  logic [CW-1:0]                         fill;
  logic in_hs, full, out_free, flush_stall, flush_take, load;

  assign out_free = !obuf_q.vld || out_ready;

`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
  // A flush waiting on a stalled output also holds back input so the partial word stays put.
  assign flush_stall = flush && obuf_q.vld && !out_ready;
  assign flush_take  = flush && !clear && !full && (fill != '0) && out_free;
`else
  assign flush_stall = 1'b0;
  assign flush_take  = 1'b0;
`endif

  assign in_ready = rstn && !clear && !flush_stall &&
                    ((idx_q != IW'(PACK_RATIO-1)) || out_free);
  assign in_hs    = in_valid && in_ready;
  assign full     = in_hs && (idx_q == IW'(PACK_RATIO-1));
  assign fill     = CW'(idx_q) + CW'(in_hs);
  assign load     = full || flush_take;

  // Accumulator lanes are zeroed on every load so unfilled lanes read as zero.
  for (genvar k = 0; k < PACK_RATIO; k++) begin : g_lane
    assign lane_we[k]  = in_hs && (idx_q == IW'(k));
    assign acc_nxt[k]  = lane_we[k] ? in_data : acc_q[k];
    assign keep_nxt[k] = fill > CW'(k);

    stream_width_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clear || load),
      .we   (lane_we[k]),
      .d    (in_data),
      .q    (acc_q[k])
    );
  end

  always_comb begin
    obuf_d = obuf_q;
    idx_d  = idx_q;
    if (clear) begin
      obuf_d = '0;
      idx_d  = '0;
    end else if (load) begin
      obuf_d.vld  = 1'b1;
      obuf_d.keep = keep_nxt;
      obuf_d.data = acc_nxt;
      idx_d       = '0;
    end else begin
      if (out_ready) obuf_d.vld = 1'b0;
      if (in_hs)     idx_d      = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      obuf_q <= '0;
      idx_q  <= '0;
    end else begin
      obuf_q <= obuf_d;
      idx_q  <= idx_d;
    end
  end

  assign out_data  = obuf_q.data;
  assign out_keep  = obuf_q.keep;
  assign out_valid = obuf_q.vld;
  assign count     = CW'(idx_q);
endmodule

// File: tb/tb_stream_width_packer.sv
// Self-checking bench for stream_width_packer: directed scenarios plus a randomized run
// compared against a queue-based packing model.

module tb_stream_width_packer;
  localparam int DW = 8;
  localparam int PR = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [DW*PR-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [PR-1:0]  out_keep;
  logic           clear;
`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
  logic           flush_s;
`endif
  logic [2:0]     count;

  int total = 0;
  int bad   = 0;

  logic           obs_in_ready, obs_in_hs, obs_out_hs, obs_out_valid;
  logic [DW*PR-1:0] obs_out_data;
  logic [PR-1:0]  obs_out_keep;

  always #5 clk = ~clk;

  stream_width_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_keep  (out_keep),
    .clear     (clear),
`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
    .flush     (flush_s),
`endif
    .count     (count)
  );

  // One clock cycle: drive, sample what the coming edge will see, then step past the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    obs_in_ready  = in_ready;
    obs_in_hs     = v && in_ready;
    obs_out_valid = out_valid;
    obs_out_hs    = out_valid && ordy;
    obs_out_data  = out_data;
    obs_out_keep  = out_keep;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%0h want=0", out_data); end
    total++; if (out_keep !== '0) begin bad++; $display("FAIL rst_keep got=%0h want=0", out_keep); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    rstn = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%0b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [DW-1:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, w[i], 1'b1, 1'b0);
      total++; if (obs_in_hs !== 1'b1) begin bad++; $display("FAIL basic_accept%0d got=%0b want=1", i, obs_in_hs); end
      total++; if (count !== 3'((i + 1) % 4)) begin bad++; $display("FAIL basic_count%0d got=%0d want=%0d", i, count, (i + 1) % 4); end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
    total++; if (out_data !== 32'h44332211) begin bad++; $display("FAIL basic_data got=%0h want=44332211", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL basic_keep got=%0h want=f", out_keep); end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b want=0", out_valid); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, DW'(i + 1), 1'b0, 1'b0);
      total++; if (obs_in_hs !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%0b want=1", i, obs_in_hs); end
    end
    cyc(1'b1, 8'h08, 1'b0, 1'b0);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%0b want=0", obs_in_ready); end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL bp_count got=%0d want=3", count); end
    total++; if (out_data !== 32'h04030201) begin bad++; $display("FAIL bp_hold got=%0h want=04030201", out_data); end
    cyc(1'b1, 8'h08, 1'b1, 1'b0);
    total++; if (!(obs_in_hs && obs_out_hs)) begin bad++; $display("FAIL bp_both_hs got=%0b%0b want=11", obs_in_hs, obs_out_hs); end
    total++; if (obs_out_data !== 32'h04030201) begin bad++; $display("FAIL bp_first got=%0h want=04030201", obs_out_data); end
    total++; if (out_valid !== 1'b1 || out_data !== 32'h08070605) begin bad++; $display("FAIL bp_second got=%0b/%0h want=1/08070605", out_valid, out_data); end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b want=0", out_valid); end
  endtask

  task automatic test_clear;
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b1);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%0b want=0", obs_in_ready); end
    total++; if (count !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL clr_state got=%0d/%0b want=0/0", count, out_valid); end
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(i + 1), 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin bad++; $display("FAIL clr_next got=%0b/%0h want=1/04030201", out_valid, out_data); end
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0]    w [64];
    logic [DW*PR-1:0] exp_w;
    int nout = 0;
    for (int i = 0; i < 64; i++) w[i] = DW'($urandom);
    for (int c = 0; c <= 64; c++) begin
      cyc(c < 64, (c < 64) ? w[c] : '0, 1'b1, 1'b0);
      if (c < 64) begin
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%0b want=1", c, obs_in_ready); end
      end
      if (obs_out_hs) begin
        exp_w = '0;
        for (int l = 0; l < PR; l++) exp_w[l*DW +: DW] = w[(4*nout + l) % 64];
        total++; if (c != 4 * nout + 4) begin bad++; $display("FAIL b2b_slot got=%0d want=%0d", c, 4 * nout + 4); end
        total++; if (obs_out_data !== exp_w) begin bad++; $display("FAIL b2b_data got=%0h want=%0h", obs_out_data, exp_w); end
        nout++;
      end
    end
    total++; if (nout != 16) begin bad++; $display("FAIL b2b_nout got=%0d want=16", nout); end
  endtask

  task automatic test_random;
    logic [DW-1:0]    pend [$];
    logic [DW*PR-1:0] expq [$];
    logic [DW*PR-1:0] w;
    logic v, ordy;
    logic [DW-1:0] d;
    int guard = 0;
    for (int c = 0; c < 400 + guard; c++) begin
      if (c < 400) begin
        v    = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 6);
        d    = DW'($urandom);
      end else begin
        v = 1'b0; ordy = 1'b1; d = '0;
        if (expq.size() > 0 && guard < 20) guard++;
      end
      cyc(v, d, ordy, 1'b0);
      if (ordy) begin
        total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=1", c, obs_in_ready); end
      end
      if (obs_out_hs) begin
        total++;
        if (expq.size() == 0 || obs_out_data !== expq[0] || obs_out_keep !== 4'hF) begin
          bad++; $display("FAIL rnd_out c=%0d got=%0h/%0h want=%0h/f", c, obs_out_data, obs_out_keep, (expq.size() > 0) ? expq[0] : '0);
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (obs_out_valid && !ordy) begin
        total++; if (out_valid !== 1'b1 || out_data !== obs_out_data) begin bad++; $display("FAIL rnd_stable c=%0d got=%0h want=%0h", c, out_data, obs_out_data); end
      end
      if (obs_in_hs) begin
        pend.push_back(d);
        if (pend.size() == PR) begin
          w = '0;
          for (int l = 0; l < PR; l++) w[l*DW +: DW] = pend[l];
          expq.push_back(w);
          pend.delete();
        end
      end
      total++; if (count !== 3'(pend.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, pend.size()); end
    end
    total++; if (expq.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d want=0 left", expq.size()); end
    cyc(1'b0, '0, 1'b1, 1'b1);
    total++; if (count !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL rnd_clear got=%0d/%0b want=0/0", count, out_valid); end
  endtask

`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
  task automatic test_flush;
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    flush_s = 1'b1;
    cyc(1'b1, 8'hCC, 1'b1, 1'b0);
    flush_s = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h00CCBBAA) begin bad++; $display("FAIL fl_data got=%0b/%0h want=1/00ccbbaa", out_valid, out_data); end
    total++; if (out_keep !== 4'b0111) begin bad++; $display("FAIL fl_keep got=%0b want=0111", out_keep); end
    total++; if (count !== '0) begin bad++; $display("FAIL fl_count got=%0d want=0", count); end
    cyc(1'b0, '0, 1'b1, 1'b0);
    flush_s = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    flush_s = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_empty got=%0b want=0", out_valid); end
  endtask
`endif

  task automatic test_reset_midword;
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
    total++; if (count !== 3'd2 || out_valid !== 1'b1) begin bad++; $display("FAIL mid_setup got=%0d/%0b want=2/1", count, out_valid); end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", out_valid); end
    total++; if (count !== '0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL mid_data got=%0h want=0", out_data); end
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_release got=%0b want=1", in_ready); end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear = 1'b0;
`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
    flush_s = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_backpressure;
    test_clear;
    test_back_to_back;
    test_random;
`ifdef STREAM_WIDTH_PACKER_FLUSH_EN
    test_flush;
`endif
    test_reset_midword;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
